// File: rtl/hp_pkg.sv
// Shared definitions for the binary16 class generator: class bit positions,
// per-class magnitude ranges and the generator FSM state type.
package hp_pkg;

  localparam int unsigned CLS_SNAN = 5;
  localparam int unsigned CLS_QNAN = 4;
  localparam int unsigned CLS_INF  = 3;
  localparam int unsigned CLS_ZERO = 2;
  localparam int unsigned CLS_SUB  = 1;
  localparam int unsigned CLS_NORM = 0;

  // Inclusive magnitude ranges over bits 14:0, kept 16 bits wide for compare headroom.
  localparam logic [15:0] HP_SNAN_LO = 16'h7C01;
  localparam logic [15:0] HP_SNAN_HI = 16'h7DFF;
  localparam logic [15:0] HP_QNAN_LO = 16'h7E00;
  localparam logic [15:0] HP_QNAN_HI = 16'h7FFF;
  localparam logic [15:0] HP_INF_LO  = 16'h7C00;
  localparam logic [15:0] HP_INF_HI  = 16'h7C00;
  localparam logic [15:0] HP_ZERO_LO = 16'h0000;
  localparam logic [15:0] HP_ZERO_HI = 16'h0000;
  localparam logic [15:0] HP_SUB_LO  = 16'h0001;
  localparam logic [15:0] HP_SUB_HI  = 16'h03FF;
  localparam logic [15:0] HP_NORM_LO = 16'h0400;
  localparam logic [15:0] HP_NORM_HI = 16'h7BFF;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } gen_state_e;

  function automatic logic is_onehot6(logic [5:0] v);
    return (v != 6'd0) && ((v & (v - 6'd1)) == 6'd0);
  endfunction

  function automatic logic [15:0] class_lo(logic [5:0] c);
    logic [15:0] r;
    r = HP_NORM_LO;
    if (c[CLS_SNAN])      r = HP_SNAN_LO;
    else if (c[CLS_QNAN]) r = HP_QNAN_LO;
    else if (c[CLS_INF])  r = HP_INF_LO;
    else if (c[CLS_ZERO]) r = HP_ZERO_LO;
    else if (c[CLS_SUB])  r = HP_SUB_LO;
    return r;
  endfunction

  function automatic logic [15:0] class_hi(logic [5:0] c);
    logic [15:0] r;
    r = HP_NORM_HI;
    if (c[CLS_SNAN])      r = HP_SNAN_HI;
    else if (c[CLS_QNAN]) r = HP_QNAN_HI;
    else if (c[CLS_INF])  r = HP_INF_HI;
    else if (c[CLS_ZERO]) r = HP_ZERO_HI;
    else if (c[CLS_SUB])  r = HP_SUB_HI;
    return r;
  endfunction

endpackage

// File: rtl/hp_class.sv
// Binary16 classifier: one-hot {snan,qnan,infinity,zero,subnormal,normal}.
module hp_class
  import hp_pkg::*;
(
  input  logic [15:0] f,
  output logic [5:0]  cls
);

  logic [4:0] expo;
  logic [9:0] man;
  logic       unused_sign;

  assign expo        = f[14:10];
  assign man         = f[9:0];
  assign unused_sign = f[15];

  always_comb begin
    cls = '0;
    if (expo == 5'h1F) begin
      if (man == 10'd0)  cls[CLS_INF]  = 1'b1;
      else if (man[9])   cls[CLS_QNAN] = 1'b1;
      else               cls[CLS_SNAN] = 1'b1;
    end else if (expo == 5'h00) begin
      if (man == 10'd0)  cls[CLS_ZERO] = 1'b1;
      else               cls[CLS_SUB]  = 1'b1;
    end else begin
      cls[CLS_NORM] = 1'b1;
    end
  end

endmodule

// File: rtl/hp_class_gen.sv
// Streams every binary16 encoding of a requested class (+ half then - half,
// ascending magnitude) over valid/ready, cross-checking each word with hp_class.
module hp_class_gen #(
  parameter int unsigned STEP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [5:0]  class_sel,
  input  logic        abort,
  output logic [15:0] f,
  output logic        valid,
  input  logic        ready,
  output logic        last,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] count,
  output logic        chk_err
);
  import hp_pkg::*;

  localparam logic [15:0] Step16 = 16'(STEP);

  gen_state_e  state_q, state_d;
  logic [5:0]  cls_q, cls_d;
  logic [15:0] mag_q, mag_d;
  logic        sign_q, sign_d;
  logic [15:0] count_q, count_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        chk_q, chk_d;

  logic [15:0] mag_nxt;
  logic [15:0] lo, hi;
  logic [5:0]  f_cls;
  logic        fire;

  // mag is 16 bits so mag+STEP past 0x7FFF stays a correct compare against hi.
  assign mag_nxt = mag_q + Step16;
  assign lo      = class_lo(cls_q);
  assign hi      = class_hi(cls_q);

  assign f       = {sign_q, mag_q[14:0]};
  assign valid   = (state_q == StRun);
  assign busy    = (state_q != StIdle);
  assign last    = valid && sign_q && (mag_nxt > hi);
  assign fire    = valid && ready;
  assign done    = done_q;
  assign err     = err_q;
  assign count   = count_q;
  assign chk_err = chk_q;

  hp_class u_chk (
    .f   (f),
    .cls (f_cls)
  );

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    mag_d   = mag_q;
    sign_d  = sign_q;
    count_d = count_q;
    chk_d   = chk_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          if (is_onehot6(class_sel)) begin
            cls_d   = class_sel;
            mag_d   = class_lo(class_sel);
            sign_d  = 1'b0;
            count_d = '0;
            chk_d   = 1'b0;
            state_d = StRun;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (fire) begin
          count_d = count_q + 16'd1;
          if (f_cls != cls_q) chk_d = 1'b1;
          if (mag_nxt > hi) begin
            if (!sign_q) begin
              sign_d = 1'b1;
              mag_d  = lo;
            end else begin
              state_d = StIdle;
              done_d  = 1'b1;
            end
          end else begin
            mag_d = mag_nxt;
          end
        end
        // Abort overrides completion: a final handshake still counts, but no done.
        if (abort) begin
          state_d = StIdle;
          done_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cls_q   <= '0;
      mag_q   <= '0;
      sign_q  <= 1'b0;
      count_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      chk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      mag_q   <= mag_d;
      sign_q  <= sign_d;
      count_q <= count_d;
      done_q  <= done_d;
      err_q   <= err_d;
      chk_q   <= chk_d;
    end
  end

endmodule
